// File: rtl/twiddle_pkg.sv
// rtl/twiddle_pkg.sv - shared constants, helpers and stage record for the twiddle multiplier
package twiddle_pkg;

    // Q8 rotation constants: cos/sin(pi/4) and cos/sin(pi/8), rounded to nearest
    localparam int FRAC_BITS = 8;
    localparam int K_C45     = 181;
    localparam int K_C22     = 237;
    localparam int K_S22     = 98;

    typedef enum logic [1:0] {
        CONST_C45 = 2'd0,
        CONST_C22 = 2'd1,
        CONST_S22 = 2'd2
    } const_sel_e;

    // Control part of a pipeline stage record. The quadrant bit is consumed in
    // stage 1, so only the fine index r and the direction travel onward; the
    // parameter-sized data and tag fields live beside it in the top.
    typedef struct packed {
        logic       valid;
        logic [1:0] r;
        logic       inv;
    } stage_ctl_t;

    // Width of k for k in 0..N/2-1, never narrower than one bit
    function automatic int twiddle_width(input int rank);
        int lg;
        lg = $clog2(rank);
        return (lg - 1 > 1) ? lg - 1 : 1;
    endfunction

    function automatic bit is_legal_rank(input int rank);
        return (rank == 2) || (rank == 4) || (rank == 8) || (rank == 16);
    endfunction

endpackage

// File: rtl/twiddle_const_mult.sv
// rtl/twiddle_const_mult.sv - signed multiply by a selectable fixed Q8 constant using shift-add
//
// Ports:
//   din_i  - signed multiplicand, WIDTH bits
//   sel_i  - which constant: 181, 237 or 98
//   prod_o - full-precision signed product, WIDTH+9 bits
module twiddle_const_mult
    import twiddle_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic signed [WIDTH-1:0] din_i,
    input  const_sel_e              sel_i,
    output logic signed [WIDTH+8:0] prod_o
);

    localparam int PW = WIDTH + 9;

    logic signed [PW-1:0] x;

    assign x = PW'(din_i);

    // Canonical signed-digit forms:
    //   237 = 256 - 16 - 4 + 1
    //    98 = 128 - 32 + 2
    //   181 = 256 - 64 - 16 + 4 + 1
    always_comb begin
        case (sel_i)
            CONST_C22: prod_o = (x <<< 8) - (x <<< 4) - (x <<< 2) + x;
            CONST_S22: prod_o = (x <<< 7) - (x <<< 5) + (x <<< 1);
            default:   prod_o = (x <<< 8) - (x <<< 6) - (x <<< 4) + (x <<< 2) + x;
        endcase
    end

endmodule

// File: rtl/twiddle_mult_pipe.sv
// rtl/twiddle_mult_pipe.sv - 3-stage pipelined complex multiply by W_N^k, N in {2,4,8,16}
//
// Optional feature macro: TWIDDLE_MULT_INV_EN adds input 'inv' selecting W_N^-k.
//
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   in_valid / in_ready     - input handshake; in_ready is combinational
//   twiddle                 - index k
//   din_real, din_imag      - signed input sample (a, b)
//   in_tag                  - sideband returned with the result
//   inv                     - (TWIDDLE_MULT_INV_EN only) 1 selects the conjugate twiddle
//   out_valid / out_ready   - output handshake
//   dout_real, dout_imag    - signed saturated result
//   out_tag                 - tag aligned with the result
//   out_sat                 - result was clipped
module twiddle_mult_pipe
    import twiddle_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = 10,
    parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + 1,
    parameter int TWIDDLE_RANK   = 8,
    parameter int TWIDDLE_WIDTH  = twiddle_width(TWIDDLE_RANK),
    parameter int TAG_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TWIDDLE_WIDTH-1:0]  twiddle,
    input  logic [DATA_WIDTH_IN-1:0]  din_real,
    input  logic [DATA_WIDTH_IN-1:0]  din_imag,
    input  logic [TAG_WIDTH-1:0]      in_tag,
`ifdef TWIDDLE_MULT_INV_EN
    input  logic                      inv,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH_OUT-1:0] dout_real,
    output logic [DATA_WIDTH_OUT-1:0] dout_imag,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic                      out_sat
);

    if (!is_legal_rank(TWIDDLE_RANK)) begin : g_bad_rank
        $error("twiddle_mult_pipe: TWIDDLE_RANK must be 2, 4, 8 or 16");
    end

    localparam int W1   = DATA_WIDTH_IN + 1;   // after quadrant swap/negate
    localparam int SW   = DATA_WIDTH_IN + 2;   // after fine rotation (|gain| <= 1.42)
    localparam int PW   = W1 + 9;              // constant product width
    localparam int SUMW = PW + 1;
    localparam int XW   = ((SW > DATA_WIDTH_OUT) ? SW : DATA_WIDTH_OUT) + 1;

    localparam logic signed [XW-1:0] OUT_MAX =
        {{(XW - DATA_WIDTH_OUT + 1){1'b0}}, {(DATA_WIDTH_OUT - 1){1'b1}}};
    localparam logic signed [XW-1:0] OUT_MIN = ~OUT_MAX;

    logic advance;
    logic inv_in;

`ifdef TWIDDLE_MULT_INV_EN
    assign inv_in = inv;
`else
    assign inv_in = 1'b0;
`endif

    // The whole pipe moves in lockstep whenever the output slot is free or drained
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // ---------------- stage 1: decompose k and apply the quarter turn ----------------
    logic [2:0] k_ext;
    logic       q_in;
    logic [1:0] r_in;

    assign k_ext = 3'(twiddle);

    always_comb begin
        q_in = 1'b0;
        r_in = 2'd0;
        case (TWIDDLE_RANK)
            4:  q_in = k_ext[0];
            8:  begin q_in = k_ext[1]; r_in = {1'b0, k_ext[0]}; end
            16: begin q_in = k_ext[2]; r_in = k_ext[1:0]; end
            default: ;
        endcase
    end

    logic signed [W1-1:0] a_ext, b_ext, a1_d, b1_d, a1_q, b1_q;
    stage_ctl_t           ctl1_d, ctl1_q;
    logic [TAG_WIDTH-1:0] tag1_q;

    assign a_ext = W1'($signed(din_real));
    assign b_ext = W1'($signed(din_imag));

    // -j rotation for the forward twiddle, +j for the conjugate
    always_comb begin
        a1_d = a_ext;
        b1_d = b_ext;
        if (q_in) begin
            if (inv_in) begin
                a1_d = -b_ext;
                b1_d = a_ext;
            end else begin
                a1_d = b_ext;
                b1_d = -a_ext;
            end
        end
        ctl1_d = '{valid: in_valid, r: r_in, inv: inv_in};
    end

    // ---------------- stage 2: fine rotation by (C, S) ----------------
    const_sel_e sel_c, sel_s;

    always_comb begin
        sel_c = CONST_C45;
        sel_s = CONST_C45;
        if (TWIDDLE_RANK == 16) begin
            case (ctl1_q.r)
                2'd1:    begin sel_c = CONST_C22; sel_s = CONST_S22; end
                2'd3:    begin sel_c = CONST_S22; sel_s = CONST_C22; end
                default: ;
            endcase
        end
    end

    logic signed [PW-1:0] p_ac, p_as, p_bc, p_bs;

    twiddle_const_mult #(.WIDTH(W1)) u_mul_ac (.din_i(a1_q), .sel_i(sel_c), .prod_o(p_ac));
    twiddle_const_mult #(.WIDTH(W1)) u_mul_as (.din_i(a1_q), .sel_i(sel_s), .prod_o(p_as));
    twiddle_const_mult #(.WIDTH(W1)) u_mul_bc (.din_i(b1_q), .sel_i(sel_c), .prod_o(p_bc));
    twiddle_const_mult #(.WIDTH(W1)) u_mul_bs (.din_i(b1_q), .sel_i(sel_s), .prod_o(p_bs));

    logic signed [SUMW-1:0] re_sum, im_sum;
    logic signed [SW-1:0]   a2_d, b2_d, a2_q, b2_q;
    logic                   vld2_q;
    logic [TAG_WIDTH-1:0]   tag2_q;

    always_comb begin
        if (ctl1_q.inv) begin
            re_sum = SUMW'(p_ac) - SUMW'(p_bs);
            im_sum = SUMW'(p_bc) + SUMW'(p_as);
        end else begin
            re_sum = SUMW'(p_ac) + SUMW'(p_bs);
            im_sum = SUMW'(p_bc) - SUMW'(p_as);
        end
        // Arithmetic shift floors; the rotated magnitude always fits SW bits
        if (ctl1_q.r == 2'd0) begin
            a2_d = SW'(a1_q);
            b2_d = SW'(b1_q);
        end else begin
            a2_d = SW'(re_sum >>> FRAC_BITS);
            b2_d = SW'(im_sum >>> FRAC_BITS);
        end
    end

    // ---------------- stage 3: saturate to the output width ----------------
    logic signed [XW-1:0]             re_x, im_x;
    logic signed [DATA_WIDTH_OUT-1:0] re3_d, im3_d, re3_q, im3_q;
    logic                             clip_re, clip_im;
    logic                             vld3_q, sat3_q;
    logic [TAG_WIDTH-1:0]             tag3_q;

    always_comb begin
        re_x    = XW'(a2_q);
        im_x    = XW'(b2_q);
        clip_re = 1'b1;
        clip_im = 1'b1;
        if (re_x > OUT_MAX)      re3_d = OUT_MAX[DATA_WIDTH_OUT-1:0];
        else if (re_x < OUT_MIN) re3_d = OUT_MIN[DATA_WIDTH_OUT-1:0];
        else begin
            re3_d   = re_x[DATA_WIDTH_OUT-1:0];
            clip_re = 1'b0;
        end
        if (im_x > OUT_MAX)      im3_d = OUT_MAX[DATA_WIDTH_OUT-1:0];
        else if (im_x < OUT_MIN) im3_d = OUT_MIN[DATA_WIDTH_OUT-1:0];
        else begin
            im3_d   = im_x[DATA_WIDTH_OUT-1:0];
            clip_im = 1'b0;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl1_q <= '0;
            a1_q   <= '0;
            b1_q   <= '0;
            tag1_q <= '0;
            vld2_q <= 1'b0;
            a2_q   <= '0;
            b2_q   <= '0;
            tag2_q <= '0;
            vld3_q <= 1'b0;
            re3_q  <= '0;
            im3_q  <= '0;
            sat3_q <= 1'b0;
            tag3_q <= '0;
        end else if (advance) begin
            ctl1_q <= ctl1_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            tag1_q <= in_tag;
            vld2_q <= ctl1_q.valid;
            a2_q   <= a2_d;
            b2_q   <= b2_d;
            tag2_q <= tag1_q;
            vld3_q <= vld2_q;
            re3_q  <= re3_d;
            im3_q  <= im3_d;
            sat3_q <= clip_re | clip_im;
            tag3_q <= tag2_q;
        end
    end

    assign out_valid = vld3_q;
    assign dout_real = re3_q;
    assign dout_imag = im3_q;
    assign out_tag   = tag3_q;
    assign out_sat   = sat3_q;

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// tb/tb_twiddle_mult_pipe.sv - directed-vector bench for twiddle_mult_pipe at N=8, N=16 and saturating N=4
module tb_twiddle_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [9:0] a_in, b_in;
    logic [3:0] tag_in;
    logic [2:0] k_in;
    logic       v8, v16, v4;
    logic       rdy8;
    logic       rdy_on;
`ifdef TWIDDLE_MULT_INV_EN
    logic       inv_in;
`endif

    logic        ir8, ov8, st8;
    logic [10:0] re8, im8;
    logic [3:0]  tg8;
    logic        ir16, ov16, st16;
    logic [10:0] re16, im16;
    logic [3:0]  tg16;
    logic        ir4, ov4, st4;
    logic [9:0]  re4, im4;
    logic [3:0]  tg4;

    twiddle_mult_pipe #(.TWIDDLE_RANK(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .twiddle(k_in[1:0]),
        .din_real(a_in), .din_imag(b_in), .in_tag(tag_in),
`ifdef TWIDDLE_MULT_INV_EN
        .inv(inv_in),
`endif
        .out_valid(ov8), .out_ready(rdy8), .dout_real(re8), .dout_imag(im8),
        .out_tag(tg8), .out_sat(st8)
    );

    twiddle_mult_pipe #(.TWIDDLE_RANK(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16), .twiddle(k_in),
        .din_real(a_in), .din_imag(b_in), .in_tag(tag_in),
`ifdef TWIDDLE_MULT_INV_EN
        .inv(inv_in),
`endif
        .out_valid(ov16), .out_ready(rdy_on), .dout_real(re16), .dout_imag(im16),
        .out_tag(tg16), .out_sat(st16)
    );

    twiddle_mult_pipe #(.TWIDDLE_RANK(4), .DATA_WIDTH_OUT(10)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .twiddle(k_in[0:0]),
        .din_real(a_in), .din_imag(b_in), .in_tag(tag_in),
`ifdef TWIDDLE_MULT_INV_EN
        .inv(inv_in),
`endif
        .out_valid(ov4), .out_ready(rdy_on), .dout_real(re4), .dout_imag(im4),
        .out_tag(tg4), .out_sat(st4)
    );

    logic ovv [3];
    int   orv [3];
    int   oiv [3];
    int   otg [3];
    int   osat[3];

    always_comb begin
        ovv[0] = ov8;  orv[0] = $signed(re8);  oiv[0] = $signed(im8);  otg[0] = tg8;  osat[0] = st8;
        ovv[1] = ov16; orv[1] = $signed(re16); oiv[1] = $signed(im16); otg[1] = tg16; osat[1] = st16;
        ovv[2] = ov4;  orv[2] = $signed(re4);  oiv[2] = $signed(im4);  otg[2] = tg4;  osat[2] = st4;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One sample into one instance, then wait (bounded) for its result
    task automatic single(input string name, input int dut, input int k, input int a, input int b,
                          input int tg, input int inv, input int er, input int ei, input int es);
        int lat;
        @(negedge clk);
        rdy8   = 1'b1;
        a_in   = 10'(a);
        b_in   = 10'(b);
        tag_in = 4'(tg);
        k_in   = 3'(k);
`ifdef TWIDDLE_MULT_INV_EN
        inv_in = inv[0];
`else
        if (inv != 0) $display("note: %s needs the inverse build", name);
`endif
        case (dut)
            0:       v8  = 1'b1;
            1:       v16 = 1'b1;
            default: v4  = 1'b1;
        endcase
        @(negedge clk);
        v8 = 1'b0; v16 = 1'b0; v4 = 1'b0;
        lat = 1;
        while (!ovv[dut] && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 3);
        chk({name, "_real"}, orv[dut], er);
        chk({name, "_imag"}, oiv[dut], ei);
        chk({name, "_sat"}, osat[dut], es);
        chk({name, "_tag"}, otg[dut], tg);
    endtask

    initial begin
        int sent;
        int recv;
        int extra;

        rst = 1'b1; v8 = 1'b0; v16 = 1'b0; v4 = 1'b0; rdy8 = 1'b1; rdy_on = 1'b1;
        a_in = '0; b_in = '0; tag_in = '0; k_in = '0;
`ifdef TWIDDLE_MULT_INV_EN
        inv_in = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_out_valid", ov8, 0);
        chk("rst_dout_real", orv[0], 0);
        chk("rst_dout_imag", oiv[0], 0);
        chk("rst_out_tag", tg8, 0);
        chk("rst_out_sat", st8, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", ir8, 1);

        //      name       dut k   a     b    tag inv  real  imag sat
        single("n8_k1",    0, 1,  100,    0,  1, 0,   70,  -71, 0);
        single("n8_k2",    0, 2,  100,  -50,  2, 0,  -50, -100, 0);
        single("n8_k0",    0, 0, -512,  511,  3, 0, -512,  511, 0);
        single("n8_k3",    0, 3,  100,    0,  4, 0,  -71,  -71, 0);
        single("n16_k1",   1, 1,  256,    0,  5, 0,  237,  -98, 0);
        single("n16_k3",   1, 3,  256,    0,  6, 0,   98, -237, 0);
        single("n16_k5",   1, 5,  256,    0,  7, 0,  -98, -237, 0);
        single("n16_k2",   1, 2, -512, -512,  8, 0, -724,    0, 0);
        single("n4_sat",   2, 1, -512,    0,  9, 0,    0,  511, 1);
        single("n4_k0",    2, 0, -512,  511, 10, 0, -512,  511, 0);
`ifdef TWIDDLE_MULT_INV_EN
        single("inv_n8_k1", 0, 1, 100,    0, 11, 1,   70,   70, 0);
        single("inv_n8_k2", 0, 2, 100,  -50, 12, 1,   50,  100, 0);
`endif

        // Back-to-back stream with the output stalled for cycles 2..6
        sent = 0;
        recv = 0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            @(negedge clk);
            rdy8 = !(c >= 2 && c <= 6);
            if (sent < 6) begin
                v8     = 1'b1;
                a_in   = 10'(sent * 10 + 5);
                b_in   = 10'(-sent);
                tag_in = 4'(sent + 1);
                k_in   = 3'd0;
            end else begin
                v8 = 1'b0;
            end
            #1;
            if (c == 2) chk("stream_pre_stall_in_ready", ir8, 1);
            if (c == 3) chk("stream_stall_in_ready", ir8, 0);
            if (ov8 && rdy8) begin
                chk("stream_tag", tg8, recv + 1);
                chk("stream_real", orv[0], recv * 10 + 5);
                chk("stream_imag", oiv[0], -recv);
                recv++;
            end
            if (v8 && ir8) sent++;
        end
        @(negedge clk);
        v8   = 1'b0;
        rdy8 = 1'b1;
        chk("stream_count", recv, 6);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (ov8) extra++;
        end
        chk("stream_no_dup", extra, 0);

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v8 = 1'b1; a_in = 10'(i + 1); b_in = 10'd0; tag_in = 4'(12 + i); k_in = 3'd0;
        end
        @(negedge clk);
        v8  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("flush_out_valid", ov8, 0);
        single("post_rst", 0, 1, 100, 0, 15, 0, 70, -71, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/twiddle_mult_pipe.md
Name: twiddle_mult_pipe

Overview:
Pipelined, parametrised complex twiddle multiplier for the radix-2^k butterfly PE. It multiplies one complex sample by W_N^k = cos(2πk/N) - j·sin(2πk/N) for N = TWIDDLE_RANK in {2,4,8,16}. Multiplication uses fixed shift-add constants, not DSP multipliers. The block has a 3-stage registered datapath with valid/ready flow control and a pass-through tag, so it drops directly between butterfly stages.

Parameters:
DATA_WIDTH_IN, 10, signed input component width
DATA_WIDTH_OUT, DATA_WIDTH_IN+1, signed output component width; saturation applies if narrower
TWIDDLE_RANK, 8, N; legal values 2, 4, 8, 16; any other value is an elaboration error
TWIDDLE_WIDTH, max(1, log2(TWIDDLE_RANK)-1), width of the twiddle index k (0..N/2-1)
TAG_WIDTH, 4, width of the sideband tag carried alongside the data

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts the sample this cycle
twiddle  in  TWIDDLE_WIDTH  index k
din_real  in  DATA_WIDTH_IN  signed real part a
din_imag  in  DATA_WIDTH_IN  signed imaginary part b
in_tag  in  TAG_WIDTH  sideband, returned unchanged
out_valid  out  1  output valid
out_ready  in  1  downstream accepts the output
dout_real  out  DATA_WIDTH_OUT  signed result, real part
dout_imag  out  DATA_WIDTH_OUT  signed result, imaginary part
out_tag  out  TAG_WIDTH  tag aligned with the output data
out_sat  out  1  result was clipped; qualified by out_valid

Behaviour:
- Reset: all stage valids clear; out_valid=0; dout_real=0; dout_imag=0; out_tag=0; out_sat=0. Reset asserted mid-stream flushes every in-flight sample; nothing is emitted afterwards.
- Handshake: advance = out_ready | ~out_valid. When advance=1, all three stages shift together; bubbles shift normally. in_ready = advance, combinational.
  - A sample is accepted when in_valid & in_ready.
  - out_valid, data, tag and sat are held stable while out_valid & ~out_ready.
- Latency is exactly 3 cycles from acceptance to out_valid when there is no stall. Throughput is 1 sample/cycle.
- Decompose k = q·(N/4) + r with q in {0,1}. For N=2: q=0, r=0. For N=4: r=0.
- Stage 1 (quadrant): if q=1, (a,b) becomes (b, -a); otherwise unchanged. Width is DATA_WIDTH_IN+1, so negating -2^(W-1) is exact.
- Stage 2 (fine rotation), with constants (C,S) in Q8:
  - r=0: bypass.
  - N=8, r=1: C=S=181.
  - N=16: r=1 → (237,98); r=2 → (181,181); r=3 → (98,237).
  - real = (a·C + b·S) >>> 8
  - imag = (b·C - a·S) >>> 8
  - Arithmetic uses full precision; >>> is an arithmetic shift, i.e. floor.
- Stage 3 (output): saturate each component to the DATA_WIDTH_OUT signed range. out_sat = OR of both clip events. At the default widths saturation never fires.
- An index k >= N/2 cannot occur, because TWIDDLE_WIDTH bounds k. At N=2, twiddle is ignored.

Optional Feature:
TWIDDLE_MULT_INV_EN
- Defined: adds input port inv (1 bit), sampled with the data. inv=1 selects W_N^-k:
  - quadrant rotation is (a,b) → (-b, a);
  - real = (a·C - b·S) >>> 8;
  - imag = (b·C + a·S) >>> 8.
  - inv travels with the sample through the pipeline.
- Undefined: port absent; forward twiddle only.

Decomposition:
- Package twiddle_pkg holds:
  - FRAC_BITS=8, K_C45=181, K_C22=237, K_S22=98;
  - function twiddle_width(rank);
  - function is_legal_rank(rank);
  - typedef for the stage record {valid, q/r, a, b, tag, inv}.
- Sub-module twiddle_const_mult: multiplies a signed input by one of the fixed Q8 constants using CSD shift-add, with a selectable constant. Stage 2 instantiates four of them: a·C, a·S, b·C, b·S.

Test Plan:
- N=8, k=1, a=100, b=0 → after 3 cycles dout=(70, -71).
- N=8, k=2, a=100, b=-50 → (-50, -100); k=0, a=-512, b=511 → (-512, 511); out_sat=0.
- N=16, k=1, a=256, b=0 → (237, -98); k=3 → (98, -237); k=5, a=256, b=0 → (-98, -237).
- Stream 6 back-to-back samples with out_ready low for cycles 2..6 → in_ready drops once 3 are held; all 6 emerge in order with correct tags and no loss or duplication.
- rst pulsed for 1 cycle while 3 samples are in flight → out_valid=0 on the next cycle; next output is from the first post-reset input.
- DATA_WIDTH_OUT=DATA_WIDTH_IN, N=4, k=1, a=-512, b=0 → imag saturates to 511; out_sat=1.
- With TWIDDLE_MULT_INV_EN defined, N=8, k=1, inv=1, a=100, b=0 → (70, 70).
